fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port 640x480x12-bit frame-buffer BRAM between two requesters: the VGA scan-out reader and the camera capture writer.
- Reads have absolute priority because VGA timing cannot stall.
- Camera writes are queued in an internal FIFO and drained to memory on any cycle with no read request, mainly during horizontal and vertical blanking.
- Sits between the capture block, the VGA timing block and the frame-buffer BRAM, all in the clk25 domain.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 12, pixel width (RGB444).
- FIFO_DEPTH, 256, write-queue depth in entries; must be a power of 2, minimum 4.
- FIFO_AW, 8, log2(FIFO_DEPTH).

Ports:
- clk25  in  1  system pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  VGA requests a read this cycle.
- rd_addr  in  ADDR_W  read address, sampled when rd_req=1.
- rd_data  out  DATA_W  read pixel.
- rd_valid  out  1  rd_data is valid this cycle.
- wr_en  in  1  camera pixel write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_ready  out  1  FIFO not full; a write is accepted when wr_en=1 and wr_ready=1.
- ovf_clr  in  1  clears the sticky overflow flag.
- overflow  out  1  sticky flag: at least one write was dropped.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- mem_addr  out  ADDR_W  BRAM address, registered.
- mem_din  out  DATA_W  BRAM write data, registered.
- mem_we  out  1  BRAM write enable, registered.
- mem_dout  in  DATA_W  BRAM read data; valid one cycle after mem_addr is presented.
- drop_count  out  16  dropped-write counter; only meaningful with the optional feature.

Behaviour:
- Reset (async, active-high) clears all registers:
  - mem_we=0, mem_addr=0, mem_din=0;
  - rd_valid=0, rd_data=0;
  - FIFO empty (fifo_level=0, wr_ready=1);
  - overflow=0, drop_count=0.
  - Reset asserted mid-operation discards FIFO contents, and any mem_we pulse ends on assertion.
- Arbitration FSM, evaluated each clk25 edge. States are IDLE, READ and WRITE, held in a registered state reflecting the last cycle's grant:
  - rd_req=1 -> READ: mem_addr<=rd_addr, mem_we<=0.
  - else if FIFO non-empty -> WRITE: pop the head entry; mem_addr<=head addr, mem_din<=head data, mem_we<=1.
  - else -> IDLE: mem_we<=0; mem_addr holds its value.
- Read latency: rd_req at cycle N -> mem_addr at N+1 -> rd_data<=mem_dout, rd_valid=1 at N+2. This is fixed at 2 cycles and never stalled.
  - rd_valid is a 2-stage delay of rd_req.
  - rd_data holds its value when rd_valid=0.
- FIFO:
  - Push occurs when wr_en & wr_ready.
  - Pop occurs only on a WRITE grant.
  - Simultaneous push and pop leaves the level unchanged, and the data order is preserved.
  - A push to an empty FIFO is not poppable until the next cycle: no bypass, so minimum write latency is wr_en at N -> mem_we at N+2.
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from the level register.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH inclusive.
- Overflow:
  - wr_en=1 while full: the write is dropped and overflow<=1.
  - ovf_clr=1 clears overflow next cycle; a drop in the same cycle as ovf_clr wins, so overflow stays 1.
- Continuous rd_req starves writes indefinitely. This is acceptable because VGA leaves 160 idle cycles per line.

Optional Feature:
- Macro FB_DROP_COUNT_EN.
- Defined: drop_count is a 16-bit saturating counter.
  - Increments on each dropped write and saturates at 16'hFFFF.
  - Cleared by reset and by ovf_clr; a simultaneous drop yields 1.
- Undefined: drop_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then read only: rd_req=1 for 640 cycles with rd_addr 0..639 and preloaded memory -> rd_valid high for cycles 2..641, data matching the addresses in order, mem_we=0 throughout.
- Idle write: rd_req=0, one write addr=0x12345 data=0xABC -> mem_we=1 with mem_addr=0x12345 and mem_din=0xABC exactly 2 cycles after wr_en; fifo_level returns to 0.
- Contention: 300 writes, one per cycle, while rd_req=1 for 640 cycles (FIFO_DEPTH=256) -> wr_ready falls after 256 accepts, 44 writes dropped, overflow=1, drop_count=44 with the macro; the 256 queued entries drain in order in 256 cycles after rd_req falls.
- Simultaneous push and pop at level 5 -> level stays 5 and write order into memory matches push order.
- ovf_clr with no drop -> overflow=0 and drop_count=0 the next cycle; ovf_clr in the same cycle as a drop -> overflow=1 and drop_count=1.
- Async reset asserted during a write burst with FIFO level 100 -> mem_we=0 immediately; after release fifo_level=0, wr_ready=1 and rd_valid=0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA reads take the single BRAM port first, and
// camera writes queue in a FIFO that drains on idle cycles. Optional: FB_DROP_COUNT_EN.
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 256,
  parameter int FIFO_AW    = 8
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              ovf_clr,
  output logic              overflow,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       drop_count
);
  localparam int STAGES = 1;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state;
  wr_ent_t            fifo_q [FIFO_DEPTH];
  wr_ent_t            head;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [STAGES:0]    vld_pipe;
  logic [DATA_W-1:0]  rd_hold;
  logic               push, pop, drop;

  assign wr_ready   = (level != FULL_LVL);
  assign fifo_level = level;
  assign push       = wr_en & wr_ready;
  assign drop       = wr_en & ~wr_ready;
  assign pop        = ~rd_req & (level != '0);
  assign head       = fifo_q[rd_ptr];

  always_ff @(posedge clk25)
    if (push) fifo_q[wr_ptr] <= '{addr: wr_addr, data: wr_data};

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // mem_we is a decode of the grant register, so reset drops it at once.
  assign mem_we = (state == WRITE);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (rd_req) begin
      state    <= READ;
      mem_addr <= rd_addr;
    end else if (pop) begin
      state    <= WRITE;
      mem_addr <= head.addr;
      mem_din  <= head.data;
    end else begin
      state    <= IDLE;
    end
  end

  // BRAM output arrives together with the second valid stage; hold it afterwards.
  assign rd_valid = vld_pipe[STAGES];
  assign rd_data  = rd_valid ? mem_dout : rd_hold;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      rd_hold  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_req};
      if (rd_valid) rd_hold <= mem_dout;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef FB_DROP_COUNT_EN
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (ovf_clr)
      drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port BRAM model.
module tb_fb_port_arbiter;
  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [18:0] rd_addr = '0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic        ovf_clr = 1'b0;
  logic        overflow;
  logic [8:0]  fifo_level;
  logic [18:0] mem_addr;
  logic [11:0] mem_din;
  logic        mem_we;
  logic [11:0] mem_dout;
  logic [15:0] drop_count;

  logic        preload = 1'b0;
  logic [11:0] mem [0:(1<<19)-1];
  int          passed = 0;
  int          total  = 0;

  always #20 clk25 = ~clk25;

  fb_port_arbiter dut (
    .clk25(clk25), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .ovf_clr(ovf_clr), .overflow(overflow),
    .fifo_level(fifo_level), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .drop_count(drop_count)
  );

  function automatic logic [11:0] pat(input int a);
    return 12'((a * 7 + 3) ^ 32'h5A5);
  endfunction

  function automatic logic [15:0] dc(input int n);
`ifdef FB_DROP_COUNT_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction

  // Single-port BRAM: registered read, write-enable on the same port.
  always @(posedge clk25) begin
    if (preload) begin
      for (int i = 0; i < 640; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 19'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_din !== 12'd0) $display("FAIL reset_mem_din: got %h want 0", mem_din); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
    total++; if (rd_data !== 12'd0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
    total++; if (fifo_level !== 9'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
    total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_only();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int t = 0; t < 644; t++) begin
      rd_req  = (t < 640);
      rd_addr = 19'(t);
      tick();
      total++;
      if (rd_valid !== (t >= 1 && t <= 640))
        $display("FAIL read_valid t=%0d: got %b want %b", t, rd_valid, (t >= 1 && t <= 640));
      else passed++;
      if (t >= 1 && t <= 640) begin
        total++;
        if (rd_data !== pat(t - 1)) $display("FAIL read_data t=%0d: got %h want %h", t, rd_data, pat(t - 1));
        else passed++;
      end
      total++; if (mem_we !== 1'b0) $display("FAIL read_mem_we t=%0d: got %b want 0", t, mem_we); else passed++;
    end
    total++; if (rd_data !== pat(639)) $display("FAIL read_hold: got %h want %h", rd_data, pat(639)); else passed++;
  endtask

  task automatic test_idle_write();
    wr_en = 1'b1; wr_addr = 19'h12345; wr_data = 12'hABC;
    tick();
    wr_en = 1'b0;
    total++; if (fifo_level !== 9'd1) $display("FAIL iw_level1: got %0d want 1", fifo_level); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL iw_we_early: got %b want 0", mem_we); else passed++;
    tick();
    total++; if (mem_we !== 1'b1) $display("FAIL iw_we: got %b want 1", mem_we); else passed++;
    total++; if (mem_addr !== 19'h12345) $display("FAIL iw_addr: got %h want 12345", mem_addr); else passed++;
    total++; if (mem_din !== 12'hABC) $display("FAIL iw_din: got %h want abc", mem_din); else passed++;
    total++; if (fifo_level !== 9'd0) $display("FAIL iw_level0: got %0d want 0", fifo_level); else passed++;
    tick();
    total++; if (mem_we !== 1'b0) $display("FAIL iw_we_end: got %b want 0", mem_we); else passed++;
    total++; if (mem[19'h12345] !== 12'hABC) $display("FAIL iw_mem: got %h want abc", mem[19'h12345]); else passed++;
  endtask

  task automatic test_contention();
    for (int t = 0; t < 640; t++) begin
      rd_req  = 1'b1;
      rd_addr = '0;
      wr_en   = (t < 300);
      wr_addr = 19'(32'h40000 + t);
      wr_data = 12'(t);
      tick();
      if (t < 300) begin
        total++;
        if (fifo_level !== 9'((t + 1 < 256) ? t + 1 : 256))
          $display("FAIL cont_level t=%0d: got %0d want %0d", t, fifo_level, (t + 1 < 256) ? t + 1 : 256);
        else passed++;
        total++;
        if (wr_ready !== (t + 1 < 256)) $display("FAIL cont_ready t=%0d: got %b want %b", t, wr_ready, (t + 1 < 256));
        else passed++;
        total++;
        if (overflow !== (t >= 256)) $display("FAIL cont_ovf t=%0d: got %b want %b", t, overflow, (t >= 256));
        else passed++;
      end
      total++; if (mem_we !== 1'b0) $display("FAIL cont_starve t=%0d: got %b want 0", t, mem_we); else passed++;
    end
    wr_en = 1'b0;
    total++; if (drop_count !== dc(44)) $display("FAIL cont_drops: got %0d want %0d", drop_count, dc(44)); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL cont_ovf_end: got %b want 1", overflow); else passed++;
    rd_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick();
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 19'(32'h40000 + k) || mem_din !== 12'(k))
        $display("FAIL drain k=%0d: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                 k, mem_we, mem_addr, mem_din, 19'(32'h40000 + k), 12'(k));
      else passed++;
      total++;
      if (fifo_level !== 9'(255 - k)) $display("FAIL drain_level k=%0d: got %0d want %0d", k, fifo_level, 255 - k);
      else passed++;
    end
    tick();
    total++; if (mem_we !== 1'b0) $display("FAIL drain_done: got %b want 0", mem_we); else passed++;
  endtask

  task automatic test_push_pop();
    for (int t = 0; t < 15; t++) begin
      rd_req  = (t < 5);
      wr_en   = (t < 10);
      wr_addr = 19'(32'h100 + t);
      wr_data = 12'(32'h200 + t);
      tick();
      total++;
      if (fifo_level !== 9'((t < 5) ? t + 1 : (t < 10) ? 5 : 14 - t))
        $display("FAIL pp_level t=%0d: got %0d want %0d", t, fifo_level, (t < 5) ? t + 1 : (t < 10) ? 5 : 14 - t);
      else passed++;
      if (t >= 5) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 19'(32'h100 + t - 5) || mem_din !== 12'(32'h200 + t - 5))
          $display("FAIL pp_order t=%0d: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                   t, mem_we, mem_addr, mem_din, 19'(32'h100 + t - 5), 12'(32'h200 + t - 5));
        else passed++;
      end
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", overflow); else passed++;
    total++; if (drop_count !== 16'd0) $display("FAIL clr_count: got %0d want 0", drop_count); else passed++;
    rd_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = 19'(32'h600 + i); wr_data = 12'(i);
      tick();
    end
    total++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wr_ready); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL clr_drop_ovf: got %b want 1", overflow); else passed++;
    total++; if (drop_count !== dc(1)) $display("FAIL clr_drop_count: got %0d want %0d", drop_count, dc(1)); else passed++;
    tick();
    total++; if (drop_count !== dc(2)) $display("FAIL drop_again: got %0d want %0d", drop_count, dc(2)); else passed++;
    wr_en = 1'b0;
    rd_req = 1'b0;
    for (int n = 0; n < 300 && fifo_level != 0; n++) tick();
    total++; if (fifo_level !== 9'd0) $display("FAIL ovf_drain: got %0d want 0", fifo_level); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1; wr_addr = 19'(32'h700 + i); wr_data = 12'(i);
      tick();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 19'(32'h800 + i);
      tick();
    end
    total++; if (mem_we !== 1'b1) $display("FAIL burst_we: got %b want 1", mem_we); else passed++;
    total++; if (fifo_level !== 9'd100) $display("FAIL burst_level: got %0d want 100", fifo_level); else passed++;
    #5 reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL arst_we: got %b want 0", mem_we); else passed++;
    total++; if (fifo_level !== 9'd0) $display("FAIL arst_level: got %0d want 0", fifo_level); else passed++;
    wr_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++; if (fifo_level !== 9'd0) $display("FAIL post_level: got %0d want 0", fifo_level); else passed++;
    total++; if (wr_ready !== 1'b1) $display("FAIL post_ready: got %b want 1", wr_ready); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL post_rd_valid: got %b want 0", rd_valid); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL post_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 19'd0) $display("FAIL post_addr: got %h want 0", mem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_idle_write();
    test_contention();
    test_push_pop();
    test_ovf_clr();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
